// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-outstanding memory port between instruction and data requesters.
// Optional MEM_ARBITER_ROUND_ROBIN_EN: alternate grants on contention (default: data wins).

typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_spec;
    logic        mem_instr;
    logic [1:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
} mem_in_type;

typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        mem_ready;
} mem_out_type;

module mem_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output mem_in_type  mem_in,
    input  mem_out_type mem_out
);

    // Handshake: a side's request is a one-cycle mem_valid pulse; its response is the single
    // cycle where its mem_ready is high. The memory takes a new mem_valid in its ready cycle.
    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

    state_t     state, state_next;
    mem_in_type ireq, ireq_next, dreq, dreq_next;
    mem_in_type icand, dcand;
    logic       ipend, ipend_next, dpend, dpend_next;
    logic       idrop, idrop_next;
    logic       free, icand_v, dcand_v, grant_i, grant_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic       last_d, last_d_next;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            ipend <= 1'b0;
            dpend <= 1'b0;
            idrop <= 1'b0;
            ireq  <= '0;
            dreq  <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_d <= 1'b1;
`endif
        end else begin
            state <= state_next;
            ipend <= ipend_next;
            dpend <= dpend_next;
            idrop <= idrop_next;
            ireq  <= ireq_next;
            dreq  <= dreq_next;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_d <= last_d_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        ipend_next = ipend;
        dpend_next = dpend;
        idrop_next = idrop;
        ireq_next  = ireq;
        dreq_next  = dreq;
        mem_in     = '0;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        last_d_next = last_d;
`endif

        free    = (state == IDLE) || mem_out.mem_ready;
        icand_v = imem_in.mem_valid || ipend;
        dcand_v = dmem_in.mem_valid || dpend;
        icand   = imem_in.mem_valid ? imem_in : ireq;
        dcand   = dmem_in.mem_valid ? dmem_in : dreq;

        if (free) begin
            if (icand_v && dcand_v) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                grant_i = last_d;
`else
                grant_i = 1'b0;
`endif
                grant_d = !grant_i;
            end else begin
                grant_i = icand_v;
                grant_d = dcand_v;
            end
        end

        if (grant_i) begin
            mem_in           = icand;
            mem_in.mem_valid = 1'b1;
            state_next       = IBUSY;
            ipend_next       = 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_d_next      = 1'b0;
`endif
        end else if (grant_d) begin
            mem_in           = dcand;
            mem_in.mem_valid = 1'b1;
            state_next       = DBUSY;
            dpend_next       = 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_d_next      = 1'b1;
`endif
        end else if (free) begin
            state_next = IDLE;
        end

        // A live request that was not granted this cycle becomes (or replaces) the pending copy.
        if (!grant_i && imem_in.mem_valid) begin
            ipend_next = 1'b1;
            ireq_next  = imem_in;
        end
        if (!grant_d && dmem_in.mem_valid) begin
            dpend_next = 1'b1;
            dreq_next  = dmem_in;
        end

        // A redirect only stales an access that will still complete later.
        if (state == IBUSY) begin
            if (mem_out.mem_ready)
                idrop_next = 1'b0;
            else if (imem_in.mem_valid && imem_in.mem_spec)
                idrop_next = 1'b1;
        end
    end

    always_comb begin
        imem_out.mem_rdata = mem_out.mem_rdata;
        imem_out.mem_error = mem_out.mem_error;
        imem_out.mem_ready = mem_out.mem_ready && (state == IBUSY) && !idrop;
        dmem_out.mem_rdata = mem_out.mem_rdata;
        dmem_out.mem_error = mem_out.mem_error;
        dmem_out.mem_ready = mem_out.mem_ready && (state == DBUSY);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; the memory side is driven directly by the steps below.
// Honors MEM_ARBITER_ROUND_ROBIN_EN when computing contention expectations.

module tb_mem_arbiter;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock;
    logic        reset;
    mem_in_type  imem_in, dmem_in, mem_in;
    mem_out_type imem_out, dmem_out, mem_out;

    int tests;
    int fails;

    mem_arbiter dut (
        .clock    (clock),
        .reset    (reset),
        .imem_in  (imem_in),
        .imem_out (imem_out),
        .dmem_in  (dmem_in),
        .dmem_out (dmem_out),
        .mem_in   (mem_in),
        .mem_out  (mem_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge; inputs change here, checks follow #1 later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        imem_in = '0;
        dmem_in = '0;
        mem_out = '0;
    endtask

    task automatic ireq(input logic [31:0] addr, input logic spec);
        imem_in           = '0;
        imem_in.mem_valid = 1'b1;
        imem_in.mem_instr = 1'b1;
        imem_in.mem_spec  = spec;
        imem_in.mem_addr  = addr;
    endtask

    task automatic dreq(input logic [31:0] addr);
        dmem_in           = '0;
        dmem_in.mem_valid = 1'b1;
        dmem_in.mem_addr  = addr;
    endtask

    task automatic ready(input logic [31:0] rdata, input logic err);
        mem_out.mem_ready = 1'b1;
        mem_out.mem_rdata = rdata;
        mem_out.mem_error = err;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clear_inputs();
        reset = 1'b0;
        step();
        step();
        #1;
        chk("rst_mem_valid", 32'(mem_in.mem_valid), 32'd0);
        chk("rst_i_ready", 32'(imem_out.mem_ready), 32'd0);
        chk("rst_d_ready", 32'(dmem_out.mem_ready), 32'd0);
        reset = 1'b1;
        step();

        // Basic instruction fetch, zero issue latency
        ireq(32'h100, 1'b0);
        #1;
        chk("t1_valid", 32'(mem_in.mem_valid), 32'd1);
        chk("t1_addr", mem_in.mem_addr, 32'h100);
        chk("t1_instr", 32'(mem_in.mem_instr), 32'd1);
        step();
        clear_inputs();
        #1;
        chk("t1_busy_valid", 32'(mem_in.mem_valid), 32'd0);
        chk("t1_busy_iready", 32'(imem_out.mem_ready), 32'd0);
        step();
        ready(32'h13, 1'b0);
        #1;
        chk("t1_iready", 32'(imem_out.mem_ready), 32'd1);
        chk("t1_rdata", imem_out.mem_rdata, 32'h13);
        chk("t1_dready", 32'(dmem_out.mem_ready), 32'd0);
        chk("t1_idle_valid", 32'(mem_in.mem_valid), 32'd0);
        step();
        clear_inputs();

        // Data request pends behind instruction access and issues back-to-back
        ireq(32'h100, 1'b0);
        step();
        clear_inputs();
        dreq(32'h2000);
        #1;
        chk("t2_pend_no_issue", 32'(mem_in.mem_valid), 32'd0);
        step();
        clear_inputs();
        ready(32'hAA, 1'b0);
        #1;
        chk("t2_iready", 32'(imem_out.mem_ready), 32'd1);
        chk("t2_dready_none", 32'(dmem_out.mem_ready), 32'd0);
        chk("t2_issue_valid", 32'(mem_in.mem_valid), 32'd1);
        chk("t2_issue_addr", mem_in.mem_addr, 32'h2000);
        step();
        ready(32'hBB, 1'b0);
        #1;
        chk("t2_dready", 32'(dmem_out.mem_ready), 32'd1);
        chk("t2_iready_none", 32'(imem_out.mem_ready), 32'd0);
        chk("t2_drdata", dmem_out.mem_rdata, 32'hBB);
        chk("t2_after_valid", 32'(mem_in.mem_valid), 32'd0);
        step();
        clear_inputs();

        // Pending data request: latest one wins
        ireq(32'h100, 1'b0);
        step();
        clear_inputs();
        dreq(32'h2000);
        step();
        dreq(32'h2004);
        step();
        clear_inputs();
        ready(32'h1, 1'b0);
        #1;
        chk("t3_latest_addr", mem_in.mem_addr, 32'h2004);
        step();
        clear_inputs();
        ready(32'h2, 1'b0);
        #1;
        chk("t3_dready", 32'(dmem_out.mem_ready), 32'd1);
        step();
        clear_inputs();

        // Speculative redirect before ready: stale response suppressed
        ireq(32'h100, 1'b0);
        step();
        clear_inputs();
        ireq(32'h400, 1'b1);
        #1;
        chk("t4_spec_no_issue", 32'(mem_in.mem_valid), 32'd0);
        step();
        clear_inputs();
        ready(32'h11, 1'b0);
        #1;
        chk("t4_dropped", 32'(imem_out.mem_ready), 32'd0);
        chk("t4_issue_valid", 32'(mem_in.mem_valid), 32'd1);
        chk("t4_issue_addr", mem_in.mem_addr, 32'h400);
        chk("t4_issue_spec", 32'(mem_in.mem_spec), 32'd1);
        step();
        clear_inputs();
        ready(32'h22, 1'b0);
        #1;
        chk("t4_iready", 32'(imem_out.mem_ready), 32'd1);
        chk("t4_rdata", imem_out.mem_rdata, 32'h22);
        step();
        clear_inputs();

        // Redirect in the same cycle as ready: response forwarded, redirect issues immediately
        ireq(32'h100, 1'b0);
        step();
        clear_inputs();
        ready(32'h33, 1'b0);
        ireq(32'h500, 1'b1);
        #1;
        chk("t5_forwarded", 32'(imem_out.mem_ready), 32'd1);
        chk("t5_issue_addr", mem_in.mem_addr, 32'h500);
        chk("t5_issue_valid", 32'(mem_in.mem_valid), 32'd1);
        step();
        clear_inputs();
        ready(32'h44, 1'b0);
        #1;
        chk("t5_iready", 32'(imem_out.mem_ready), 32'd1);
        step();
        clear_inputs();

        // Error response on a data access
        dreq(32'h3000);
        step();
        clear_inputs();
        ready(32'h0, 1'b1);
        #1;
        chk("t6_dready", 32'(dmem_out.mem_ready), 32'd1);
        chk("t6_derror", 32'(dmem_out.mem_error), 32'd1);
        chk("t6_iready", 32'(imem_out.mem_ready), 32'd0);
        step();
        clear_inputs();

        // Reset during DBUSY; late ready is ignored
        dreq(32'h2000);
        step();
        clear_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
        ready(32'h55, 1'b0);
        #1;
        chk("t7_late_dready", 32'(dmem_out.mem_ready), 32'd0);
        chk("t7_late_iready", 32'(imem_out.mem_ready), 32'd0);
        chk("t7_no_issue", 32'(mem_in.mem_valid), 32'd0);
        step();
        clear_inputs();

        // Contention from freshly reset state (last grant = data)
        ireq(32'h100, 1'b0);
        dreq(32'h2000);
        #1;
        chk("t8_first_addr", mem_in.mem_addr, RR ? 32'h100 : 32'h2000);
        step();
        clear_inputs();
        ready(32'h66, 1'b0);
        #1;
        chk("t8_first_iready", 32'(imem_out.mem_ready), RR ? 32'd1 : 32'd0);
        chk("t8_first_dready", 32'(dmem_out.mem_ready), RR ? 32'd0 : 32'd1);
        chk("t8_second_addr", mem_in.mem_addr, RR ? 32'h2000 : 32'h100);
        step();
        clear_inputs();
        ready(32'h77, 1'b0);
        #1;
        chk("t8_second_iready", 32'(imem_out.mem_ready), RR ? 32'd0 : 32'd1);
        chk("t8_second_dready", 32'(dmem_out.mem_ready), RR ? 32'd1 : 32'd0);
        step();
        clear_inputs();

        // Second contention: round robin now favours instruction
        ireq(32'h104, 1'b0);
        dreq(32'h2008);
        #1;
        chk("t9_first_addr", mem_in.mem_addr, RR ? 32'h104 : 32'h2008);
        step();
        clear_inputs();
        ready(32'h88, 1'b0);
        #1;
        chk("t9_second_addr", mem_in.mem_addr, RR ? 32'h2008 : 32'h104);
        step();
        clear_inputs();
        ready(32'h99, 1'b0);
        #1;
        chk("t9_last_ready", 32'(imem_out.mem_ready | dmem_out.mem_ready), 32'd1);
        step();
        clear_inputs();
        #1;
        chk("t9_idle_valid", 32'(mem_in.mem_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single external memory port between the fetch stage's instruction port (`imem_in`/`imem_out`) and the data port (`dmem_in`/`dmem_out`).
- The memory port supports one outstanding access.
- Accepts single-cycle request pulses from either side and holds a one-deep pending request per side.
- Grants the memory to one side at a time and routes each response only to its owner; discards responses made stale by a speculative redirect.

## Interface

Parameters:
- none (priority policy selected by macro, see Configuration)

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low; state cleared on a rising edge while `reset==0`.
- `imem_in`  in  mem_in_type  instruction request: `mem_valid`, `mem_fence`, `mem_spec`, `mem_instr`, `mem_mode`, `mem_addr[31:0]`, `mem_wdata[31:0]`, `mem_wstrb[3:0]`.
- `imem_out`  out  mem_out_type  instruction response: `mem_rdata[31:0]`, `mem_error`, `mem_ready`.
- `dmem_in`  in  mem_in_type  data request, same fields.
- `dmem_out`  out  mem_out_type  data response.
- `mem_in`  out  mem_in_type  request to the memory.
- `mem_out`  in  mem_out_type  response from the memory.

## Operation

- States:
  - IDLE: no access outstanding.
  - IBUSY: instruction access outstanding.
  - DBUSY: data access outstanding.
- Pending registers:
  - `ipend`/`ireq`: one-deep; hold a full mem_in_type copy.
  - `dpend`/`dreq`: one-deep; hold a full mem_in_type copy.
  - `idrop`: 1 bit.
- Candidates each cycle:
  - instruction candidate = `imem_in` if `imem_in.mem_valid`, else `ireq` if `ipend`.
  - data candidate = `dmem_in` if `dmem_in.mem_valid`, else `dreq` if `dpend`.
- Issue slot: the port is free in IDLE, and in IBUSY/DBUSY during the cycle in which `mem_out.mem_ready==1`.
- Issue rule in a free slot:
  - grant one candidate; drive it on `mem_in` with `mem_valid=1`.
  - next state = IBUSY or DBUSY according to the grant; clear that side's pending bit.
  - a non-granted live request is latched into its pending register.
  - no candidate: `mem_in.mem_valid=0`, next state IDLE.
- Not free (busy, no ready): every live request is latched into its pending register; `mem_in.mem_valid=0`.
- Response routing:
  - `mem_rdata` and `mem_error` go to both `imem_out` and `dmem_out` combinationally.
  - `imem_out.mem_ready = mem_out.mem_ready & (state==IBUSY) & ~idrop`.
  - `dmem_out.mem_ready = mem_out.mem_ready & (state==DBUSY)`.
- Speculative redirect (`imem_in.mem_valid & imem_in.mem_spec`):
  - replaces `ireq`.
  - if state==IBUSY and no ready this cycle: set `idrop`. The next instruction response is suppressed and `idrop` is cleared on it.
- A new request from a side that already has its pending bit set overwrites the pending copy (latest wins).
- `mem_fence`, `mem_spec`, `mem_mode` and `mem_instr` pass through unchanged with the granted request.
- `mem_in` outputs are 0 whenever `mem_valid==0`.

## Timing

- Reset values:
  - state = IDLE; `ipend`, `dpend` and `idrop` = 0.
  - `mem_in.mem_valid=0`; `imem_out.mem_ready=0`; `dmem_out.mem_ready=0`.
- Issue latency:
  - 0 cycles: a request arriving in a free slot appears on `mem_in` in the same cycle.
  - pending requests issue in the cycle the current access completes, back-to-back with no bubble.
- Memory contract: the memory accepts a new `mem_valid` in the same cycle it asserts `mem_ready`.
- Response latency: 0 cycles added over the memory's own latency.
- Simultaneous `imem_in.mem_spec` and a `mem_ready` completing an IBUSY access:
  - the completing response is forwarded, not dropped.
  - the spec request competes in the free slot in that same cycle.
- Reset mid-access: all state is cleared. A late `mem_ready` arriving in IDLE is ignored and not forwarded to either side.

## Configuration

- `MEM_ARBITER_ROUND_ROBIN_EN` defined:
  - when both candidates compete in a free slot, grant the side not granted last.
  - a 1-bit last-grant register (reset: data) records the previous grant.
- Undefined: fixed priority, data over instruction.

## Test plan

- Idle, `imem_in` valid with addr 0x100 → `mem_in.mem_addr=0x100` and `mem_valid=1` in the same cycle. Memory ready 2 cycles later with rdata 0x00000013 → `imem_out.mem_ready=1` with 0x00000013; `dmem_out.mem_ready=0`.
- IBUSY, `dmem_in` load at 0x2000 → `dpend=1`. At instruction ready, `mem_in` shows 0x2000 in the same cycle. The next ready goes to `dmem_out` only.
- Both sides request at 0x100 and 0x2000 in the same idle cycle → data issued first, instruction second. Under `MEM_ARBITER_ROUND_ROBIN_EN`, a second simultaneous pair is granted instruction first.
- IBUSY on 0x100, spec request to 0x400 before ready → response for 0x100 is not forwarded. 0x400 issues in that ready cycle, and only its response raises `imem_out.mem_ready`.
- Reset low for one cycle during DBUSY, memory ready arrives afterwards → neither `mem_ready` output asserts; state IDLE.
- Memory returns `mem_error=1` on a data access → `dmem_out.mem_error=1` together with `dmem_out.mem_ready=1`.
